// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Drain side of a first-word-fall-through FIFO. Pops one word at a time and
// shifts it out MSB-first on a 3-wire SPI-style link (sclk/sdata/cs_n), paced
// by a clk divider and followed by a fixed inter-frame gap with cs_n high.
//
// Ports
//   clk         in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   allows new frames to start (sampled in IDLE only)
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO head word, valid whenever fifo_empty = 0
//   fifo_rd_en  out  pop strobe (combinational, IDLE only)
//   sclk        out  serial clock, idle low
//   sdata       out  serial data, changes only while sclk is low
//   cs_n        out  frame select, active low
//   busy        out  high whenever the FSM is not in IDLE
//   frame_done  out  one-cycle pulse in the first GAP cycle
//   dbg_state   out  current FSM state (IDLE=0, SHIFT=1, GAP=2)
//
// FIFO handshake: the FIFO presents fifo_data whenever fifo_empty is low.
// fifo_rd_en is a pop strobe; the word on fifo_data is consumed by this block
// and the FIFO advances on the same rising edge where fifo_rd_en is high.
// There is no back-pressure toward the FIFO beyond not asserting fifo_rd_en.
module fifo_serial_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  sclk,
   output logic                  sdata,
   output logic                  cs_n,
   output logic                  busy,
   output logic                  frame_done,
   output logic [1:0]            dbg_state
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sdata_q, sdata_d;
   logic                  done_q, done_d;
   logic                  rd_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         div_q    <= '0;
         bitcnt_q <= '0;
         gap_q    <= '0;
         sclk_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         sdata_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         div_q    <= div_d;
         bitcnt_q <= bitcnt_d;
         gap_q    <= gap_d;
         sclk_q   <= sclk_d;
         cs_n_q   <= cs_n_d;
         sdata_q  <= sdata_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      div_d    = div_q;
      bitcnt_d = bitcnt_q;
      gap_d    = gap_q;
      sclk_d   = sclk_q;
      cs_n_d   = cs_n_q;
      done_d   = 1'b0;
      rd_en    = 1'b0;

      case (state_q)
         IDLE: begin
            // reset is folded in so no word is popped (and lost) while the
            // register reset is overriding the load below.
            rd_en = enable && !fifo_empty && !reset;
            if (rd_en) begin
               shreg_d  = fifo_data;
               bitcnt_d = '0;
               div_d    = '0;
               sclk_d   = 1'b0;
               cs_n_d   = 1'b0;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // Data moves only on the falling toggle so sdata is stable
               // for the whole high phase of sclk.
               if (sclk_q) begin
                  shreg_d  = shreg_q << 1;
                  bitcnt_d = bitcnt_q + BIT_W'(1);
                  if (bitcnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                     bitcnt_d = '0;
                     sclk_d   = 1'b0;
                     cs_n_d   = 1'b1;
                     done_d   = 1'b1;
                     gap_d    = '0;
                     state_d  = GAP;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      sdata_d = cs_n_d ? 1'b0 : shreg_d[DATA_WIDTH-1];
   end

   assign fifo_rd_en = rd_en;
   assign sclk       = sclk_q;
   assign sdata      = sdata_q;
   assign cs_n       = cs_n_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx
// Two instances: dut_a with default pacing (CLK_DIV=4, GAP_CYCLES=2) and
// dut_b with CLK_DIV=1, GAP_CYCLES=1 for the back-to-back scenario. Each has
// a queue-based FIFO model, an expected-word queue and a per-cycle monitor
// that decodes frames on sclk rises and checks them against the queue.
module tb_fifo_serial_tx;

   localparam int W  = 16;
   localparam int DA = 4;
   localparam int GA = 2;
   localparam int DB = 1;
   localparam int GB = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset    = 1'b1;
   logic enable_a = 1'b0;
   logic enable_b = 1'b0;

   logic         fifo_empty_a = 1'b1, fifo_empty_b = 1'b1;
   logic [W-1:0] fifo_data_a  = '0,   fifo_data_b  = '0;
   logic         fifo_rd_en_a, sclk_a, sdata_a, cs_n_a, busy_a, frame_done_a;
   logic         fifo_rd_en_b, sclk_b, sdata_b, cs_n_b, busy_b, frame_done_b;
   logic [1:0]   dbg_state_a, dbg_state_b;

   fifo_serial_tx #(.DATA_WIDTH(W), .CLK_DIV(DA), .GAP_CYCLES(GA)) dut_a (
      .clk(clk), .reset(reset), .enable(enable_a),
      .fifo_empty(fifo_empty_a), .fifo_data(fifo_data_a),
      .fifo_rd_en(fifo_rd_en_a), .sclk(sclk_a), .sdata(sdata_a),
      .cs_n(cs_n_a), .busy(busy_a), .frame_done(frame_done_a),
      .dbg_state(dbg_state_a)
   );

   fifo_serial_tx #(.DATA_WIDTH(W), .CLK_DIV(DB), .GAP_CYCLES(GB)) dut_b (
      .clk(clk), .reset(reset), .enable(enable_b),
      .fifo_empty(fifo_empty_b), .fifo_data(fifo_data_b),
      .fifo_rd_en(fifo_rd_en_b), .sclk(sclk_b), .sdata(sdata_b),
      .cs_n(cs_n_b), .busy(busy_b), .frame_done(frame_done_b),
      .dbg_state(dbg_state_b)
   );

   // ---------------- models / scoreboard state ----------------
   logic [W-1:0] fq_a[$], fq_b[$];
   logic [W-1:0] exp_q_a[$], exp_q_b[$];
   int pop_log_a[$], pop_log_b[$], high_log_a[$], high_log_b[$], done_log_a[$];

   typedef struct {
      int           cyc;
      logic         psclk;
      logic         pcs_n;
      logic         psdata;
      logic [W-1:0] bits;
      int           nbits;
      int           cs_low;
      int           cs_high;
      int           fall_cyc;
      int           frames;
      int           dones;
      int           pops;
      int           glitches;
   } mon_t;

   mon_t mon[2];
   int   checks = 0;
   int   errors = 0;
   logic pop_a  = 1'b0;
   logic pop_b  = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic mon_step(input int i, input logic sclk_v, input logic sdata_v,
                           input logic cs_n_v, input logic done_v, input logic pop_v,
                           input int d);
      mon_t m;
      m = mon[i];
      m.cyc++;
      if (pop_v) begin
         m.pops++;
         if (i == 0) pop_log_a.push_back(m.cyc); else pop_log_b.push_back(m.cyc);
      end
      if (!cs_n_v && m.pcs_n) begin
         check("pop_to_cs_fall", 32'(pop_v), 32'd1);
         if (i == 0) high_log_a.push_back(m.cs_high); else high_log_b.push_back(m.cs_high);
         m.bits     = '0;
         m.nbits    = 0;
         m.cs_low   = 0;
         m.cs_high  = 0;
         m.fall_cyc = m.cyc;
      end
      if (cs_n_v) m.cs_high++; else m.cs_low++;
      if (sclk_v && !m.psclk) begin
         if (cs_n_v) m.glitches++;
         else begin
            if (m.nbits == 0) check("first_rise_delay", m.cyc - m.fall_cyc, d);
            m.bits = {m.bits[W-2:0], sdata_v};
            m.nbits++;
         end
      end
      if (sclk_v && m.psclk && (sdata_v !== m.psdata)) m.glitches++;
      if (cs_n_v && (sdata_v || sclk_v)) m.glitches++;
      if (done_v) begin
         m.dones++;
         if (i == 0) done_log_a.push_back(m.cyc);
      end
      if (cs_n_v && !m.pcs_n && done_v) begin
         check("bit_count", m.nbits, W);
         check("cs_low_cycles", m.cs_low, 2 * d * W);
         if (i == 0) begin
            if (exp_q_a.size() == 0) check("sb_underflow_a", 0, 1);
            else check("frame_word_a", 32'(m.bits), 32'(exp_q_a.pop_front()));
         end else begin
            if (exp_q_b.size() == 0) check("sb_underflow_b", 0, 1);
            else check("frame_word_b", 32'(m.bits), 32'(exp_q_b.pop_front()));
         end
         m.frames++;
      end else if (done_v) begin
         check("done_without_cs_rise", 0, 1);
      end
      m.psclk  = sclk_v;
      m.pcs_n  = cs_n_v;
      m.psdata = sdata_v;
      mon[i]   = m;
   endtask

   // FIFO models: pops are honoured one negedge after the rising edge that
   // consumed them; FIFO outputs only change away from the rising edge.
   always begin
      @(negedge clk);
      mon_step(0, sclk_a, sdata_a, cs_n_a, frame_done_a, pop_a, DA);
      mon_step(1, sclk_b, sdata_b, cs_n_b, frame_done_b, pop_b, DB);
      if (pop_a) void'(fq_a.pop_front());
      if (pop_b) void'(fq_b.pop_front());
      #1;
      fifo_empty_a = (fq_a.size() == 0);
      fifo_data_a  = fifo_empty_a ? '0 : fq_a[0];
      fifo_empty_b = (fq_b.size() == 0);
      fifo_data_b  = fifo_empty_b ? '0 : fq_b[0];
      #1;
      pop_a = fifo_rd_en_a;
      pop_b = fifo_rd_en_b;
   end

   // ---------------- driver tasks ----------------
   task automatic push_a(input logic [W-1:0] w);
      fq_a.push_back(w);
      exp_q_a.push_back(w);
   endtask

   task automatic push_b(input logic [W-1:0] w);
      fq_b.push_back(w);
      exp_q_b.push_back(w);
   endtask

   task automatic settle();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_frames(input int i, input int n, input int budget);
      int k;
      k = 0;
      while (mon[i].frames < n && k < budget) begin
         settle();
         k++;
      end
      if (mon[i].frames < n) check("timeout_frames", mon[i].frames, n);
   endtask

   task automatic wait_bits_a(input int n, input int budget);
      int k;
      k = 0;
      while (!(cs_n_a == 1'b0 && mon[0].nbits >= n) && k < budget) begin
         settle();
         k++;
      end
      if (k >= budget) check("timeout_bits", mon[0].nbits, n);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   int p0, d0, f0;

   initial begin
      for (int i = 0; i < 2; i++) begin
         mon[i].psclk  = 1'b0;
         mon[i].pcs_n  = 1'b1;
         mon[i].psdata = 1'b0;
      end
      repeat (3) @(negedge clk);
      #3;
      check("rst_cs_n", 32'(cs_n_a), 32'd1);
      check("rst_sclk", 32'(sclk_a), 32'd0);
      check("rst_sdata", 32'(sdata_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_frame_done", 32'(frame_done_a), 32'd0);
      check("rst_state", 32'(dbg_state_a), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // single word
      p0 = mon[0].pops;
      d0 = mon[0].dones;
      f0 = mon[0].frames;
      push_a(16'hA5C3);
      enable_a = 1'b1;
      wait_frames(0, f0 + 1, 400);
      repeat (GA + 2) settle();
      check("t1_pops", mon[0].pops - p0, 1);
      check("t1_dones", mon[0].dones - d0, 1);
      check("t1_fifo_empty", fq_a.size(), 0);
      check("t1_idle", 32'(busy_a), 32'd0);

      // empty FIFO with enable high
      repeat (50) begin
         settle();
         check("t3_idle_outputs", 32'({fifo_rd_en_a, cs_n_a, sclk_a, busy_a}), 32'b0100);
      end

      // enable gating
      @(negedge clk);
      p0 = mon[0].pops;
      f0 = mon[0].frames;
      push_a(16'h1234);
      push_a(16'h5678);
      wait_bits_a(5, 400);
      @(negedge clk);
      enable_a = 1'b0;
      wait_frames(0, f0 + 1, 400);
      repeat (20) settle();
      check("t4_single_pop", mon[0].pops - p0, 1);
      check("t4_word_held", fq_a.size(), 1);
      @(negedge clk);
      enable_a = 1'b1;
      #3;
      check("t4_pop_on_enable", 32'(fifo_rd_en_a), 32'd1);
      wait_frames(0, f0 + 2, 400);

      // reset mid-frame
      repeat (GA + 2) settle();
      @(negedge clk);
      f0 = mon[0].frames;
      d0 = mon[0].dones;
      push_a(16'h0F0F);
      push_a(16'hC3A5);
      wait_bits_a(8, 400);
      @(negedge clk);
      reset = 1'b1;
      void'(exp_q_a.pop_front());
      @(negedge clk);
      reset = 1'b0;
      #3;
      check("t5_cs_n", 32'(cs_n_a), 32'd1);
      check("t5_sclk", 32'(sclk_a), 32'd0);
      check("t5_sdata", 32'(sdata_a), 32'd0);
      check("t5_busy", 32'(busy_a), 32'd0);
      check("t5_frame_done", 32'(frame_done_a), 32'd0);
      wait_frames(0, f0 + 1, 400);
      check("t5_dones", mon[0].dones - d0, 1);
      check("t5_fifo_empty", fq_a.size(), 0);

      // late data arriving during GAP
      repeat (GA + 2) settle();
      @(negedge clk);
      f0 = mon[0].frames;
      push_a(16'h3C96);
      wait_frames(0, f0 + 1, 400);
      @(negedge clk);
      push_a(16'h6969);
      wait_frames(0, f0 + 2, 400);
      check("t6_gap_high_run", high_log_a[$], GA + 1);
      check("t6_pop_after_done", pop_log_a[$] - done_log_a[done_log_a.size() - 2], GA + 1);

      // back-to-back on the fast instance
      @(negedge clk);
      push_b(16'h0001);
      push_b(16'h8000);
      push_b(16'hFFFF);
      enable_b = 1'b1;
      wait_frames(1, 3, 400);
      check("t2_pop_count", pop_log_b.size(), 3);
      if (pop_log_b.size() == 3 && high_log_b.size() == 3) begin
         check("t2_pop_period_1", pop_log_b[1] - pop_log_b[0], 1 + 2 * DB * W + GB);
         check("t2_pop_period_2", pop_log_b[2] - pop_log_b[1], 1 + 2 * DB * W + GB);
         check("t2_cs_high_1", high_log_b[1], GB + 1);
         check("t2_cs_high_2", high_log_b[2], GB + 1);
      end

      repeat (4) settle();
      check("glitches_a", mon[0].glitches, 0);
      check("glitches_b", mon[1].glitches, 0);
      check("sb_drained", exp_q_a.size() + exp_q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
